// File: rtl/pipe_hazard_ctrl_pkg.sv
//------------------------------------------------------------------------------
// Module : pipe_haz_pkg
// Brief  : Shared types and helpers for the pipeline hazard controller.
//          Build option: define PIPE_HAZ_FWD_EN to enable operand forwarding.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package pipe_haz_pkg;

  // Tracker entries carry a fixed-width destination; narrower cores zero-extend.
  localparam int c_REG_ADDR_W_MAX = 16;
  localparam logic [c_REG_ADDR_W_MAX-1:0] REG_ZERO = '0;

`ifdef PIPE_HAZ_FWD_EN
  localparam bit c_FWD_EN = 1'b1;
`else
  localparam bit c_FWD_EN = 1'b0;
`endif

  typedef struct packed {
    logic                        valid;
    logic [c_REG_ADDR_W_MAX-1:0] dst;
    logic                        reg_write;
    logic                        mem_read;
  } haz_entry_t;

  function automatic int fwd_sel_width(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_hazard_ctrl_match.sv
//------------------------------------------------------------------------------
// Module : pipe_haz_match
// Brief  : Compares one source operand against every tracker entry; returns
//          the load-use hit and the youngest-producer forwarding select.
//          Build option: PIPE_HAZ_FWD_EN (via pipe_haz_pkg::c_FWD_EN).
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pipe_haz_match
  import pipe_haz_pkg::*;
#(
  parameter int FWD_DEPTH = 2,
  parameter int LOAD_LAT  = 1,
  parameter int FWD_SEL_W = fwd_sel_width(FWD_DEPTH)
) (
  input  logic [c_REG_ADDR_W_MAX-1:0] i_src,
  input  logic                        i_used,
  input  haz_entry_t [FWD_DEPTH-1:0]  i_trk,
  output logic                        o_lu_hit,
  output logic [FWD_SEL_W-1:0]        o_fwd_sel
);

  logic [FWD_DEPTH-1:0] w_match;

  always_comb begin
    w_match   = '0;
    o_lu_hit  = 1'b0;
    o_fwd_sel = '0;
    for (int k = 0; k < FWD_DEPTH; k++) begin
      w_match[k] = i_trk[k].valid & i_trk[k].reg_write & i_used &
                   (i_trk[k].dst == i_src) & (i_trk[k].dst != REG_ZERO);
    end
    // Without forwarding every in-flight producer must drain to the register file.
    for (int k = 0; k < FWD_DEPTH; k++) begin
      if (w_match[k] && (c_FWD_EN ? ((k < LOAD_LAT) && i_trk[k].mem_read) : 1'b1))
        o_lu_hit = 1'b1;
    end
    // Scan oldest to youngest so the youngest producer's position is kept.
    for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
      if (w_match[k])
        o_fwd_sel = FWD_SEL_W'(k + 1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
//------------------------------------------------------------------------------
// Module : pipe_hazard_ctrl
// Brief  : Load-use stall, operand-forwarding select and branch flush for the
//          in-order MIPS pipeline. Build option: define PIPE_HAZ_FWD_EN.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pipe_hazard_ctrl
  import pipe_haz_pkg::*;
#(
  parameter  int REG_ADDR_W = 5,
  parameter  int NUM_SRC    = 2,
  parameter  int FWD_DEPTH  = 2,
  parameter  int LOAD_LAT   = 1,
  parameter  int BR_STAGE   = 2,
  localparam int FWD_SEL_W  = fwd_sel_width(FWD_DEPTH)
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            id_valid_i,
  input  logic [NUM_SRC*REG_ADDR_W-1:0]   id_src_addr_i,
  input  logic [NUM_SRC-1:0]              id_src_used_i,
  input  logic [REG_ADDR_W-1:0]           id_dst_addr_i,
  input  logic                            id_reg_write_i,
  input  logic                            id_mem_read_i,
  input  logic                            br_taken_i,
  output logic                            stall_o,
  output logic                            bubble_o,
  output logic                            flush_o,
  output logic [NUM_SRC*FWD_SEL_W-1:0]    fwd_sel_o
);

  // r_trk[0] is the instruction in EX; r_trk[k] sits k stages past EX.
  haz_entry_t [FWD_DEPTH-1:0]     r_trk;
  logic [NUM_SRC*FWD_SEL_W-1:0]   r_fwd_sel;
  logic [NUM_SRC*FWD_SEL_W-1:0]   w_sel;
  logic [NUM_SRC-1:0]             w_lu_hit;
  logic                           w_adv;
  haz_entry_t                     w_id_rec;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_op
    logic [c_REG_ADDR_W_MAX-1:0] w_src;
    assign w_src = c_REG_ADDR_W_MAX'(id_src_addr_i[i*REG_ADDR_W +: REG_ADDR_W]);

    pipe_haz_match #(
      .FWD_DEPTH (FWD_DEPTH),
      .LOAD_LAT  (LOAD_LAT),
      .FWD_SEL_W (FWD_SEL_W)
    ) u_match (
      .i_src     (w_src),
      .i_used    (id_src_used_i[i]),
      .i_trk     (r_trk),
      .o_lu_hit  (w_lu_hit[i]),
      .o_fwd_sel (w_sel[i*FWD_SEL_W +: FWD_SEL_W])
    );
  end

  // A taken branch overrides any stall: the stalled consumer is squashed anyway.
  assign flush_o  = br_taken_i;
  assign stall_o  = (|w_lu_hit) & ~br_taken_i;
  assign bubble_o = stall_o;
  assign w_adv    = id_valid_i & ~stall_o & ~br_taken_i;

  always_comb begin
    w_id_rec           = '0;
    w_id_rec.valid     = 1'b1;
    w_id_rec.dst       = c_REG_ADDR_W_MAX'(id_dst_addr_i);
    w_id_rec.reg_write = id_reg_write_i;
    w_id_rec.mem_read  = id_mem_read_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_trk     <= '0;
      r_fwd_sel <= '0;
    end else begin
      for (int k = FWD_DEPTH - 1; k >= 1; k--) begin
        r_trk[k] <= r_trk[k-1];
        // Instructions younger than the resolving branch are dropped as they shift.
        if (br_taken_i && (k < BR_STAGE))
          r_trk[k].valid <= 1'b0;
      end
      r_trk[0]  <= w_adv ? w_id_rec : '0;
      r_fwd_sel <= w_adv ? w_sel : '0;
    end
  end

  assign fwd_sel_o = c_FWD_EN ? r_fwd_sel : '0;

endmodule

`default_nettype wire
